shift_add_mult_ctrl: RTL and testbench

SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

---
 rtl/shift_add_mult_ctrl.sv | 105 ++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for an N-bit shift-and-add multiplier datapath.
// Per bit: EVAL conditionally accumulates, SHIFT advances the operands.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, bit_idx held at 0
// LOAD  | operand registers load, accumulator clears
// EVAL  | accumulate shifted multiplicand when q_lsb is set
// SHIFT | shift operands, advance bit_idx or finish after bit N-1
// DONE  | one-cycle product-valid pulse
module shift_add_mult_ctrl #(
    parameter int N = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     q_lsb,
    output logic                     load,
    output logic                     acc_en,
    output logic                     shift_en,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N+1)-1:0]   bit_idx
);

    localparam int IW = $clog2(N + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EVAL  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   bit_idx_q, bit_idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            S_IDLE: begin
                bit_idx_d = '0;
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                bit_idx_d = '0;
                state_d   = abort ? S_IDLE : S_EVAL;
            end
            S_EVAL: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    bit_idx_d = '0;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    bit_idx_d = '0;
                end else if (bit_idx_q < LAST_IDX) begin
                    state_d   = S_EVAL;
                    bit_idx_d = bit_idx_q + IW'(1);
                end else begin
                    // bit_idx is cleared on the way into DONE so it reads 0 there
                    state_d   = S_DONE;
                    bit_idx_d = '0;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                bit_idx_d = '0;
            end
            default: begin
                state_d   = S_IDLE;
                bit_idx_d = '0;
            end
        endcase
    end

    // Only acc_en looks at an input; everything else is pure state decode.
    always_comb begin
        load     = (state_q == S_LOAD);
        acc_en   = (state_q == S_EVAL) && q_lsb;
        shift_en = (state_q == S_SHIFT);
        busy     = (state_q == S_LOAD) || (state_q == S_EVAL) || (state_q == S_SHIFT);
        done     = (state_q == S_DONE);
        bit_idx  = bit_idx_q;
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Testbench for shift_add_mult_ctrl: directed scenarios plus random traffic,
// checked against a phase-count model of the multiply schedule.
module tb_shift_add_mult_ctrl;

    logic clk, rst;
    logic start, abort, q_lsb;
    logic load, acc_en, shift_en, busy, done;
    logic [2:0] bit_idx;
    logic start2, abort2, q2;
    logic load2, acc_en2, shift_en2, busy2, done2;
    logic [1:0] bit_idx2;

    int n_cmp = 0;
    int n_bad = 0;
    int ph5 = 0;
    int ph2 = 0;

    shift_add_mult_ctrl #(.N(5)) dut5 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .q_lsb(q_lsb),
        .load(load), .acc_en(acc_en), .shift_en(shift_en), .busy(busy),
        .done(done), .bit_idx(bit_idx)
    );

    shift_add_mult_ctrl #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .q_lsb(q2),
        .load(load2), .acc_en(acc_en2), .shift_en(shift_en2), .busy(busy2),
        .done(done2), .bit_idx(bit_idx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 = idle, 1 = load, 2..2n+1 = eval/shift pairs, 2n+2 = done.
    function automatic int next_phase(int ph, int n, logic s, logic a);
        if (ph == 0) return s ? 1 : 0;
        if (ph == 2*n + 2) return 0;
        if (a) return 0;
        return ph + 1;
    endfunction

    function automatic logic is_eval(int ph, int n);
        return (ph >= 2) && (ph <= 2*n + 1) && (ph % 2 == 0);
    endfunction

    function automatic logic [10:0] exp_out(int ph, int n, logic q);
        logic ev, sh;
        logic [5:0] idx;
        ev  = is_eval(ph, n);
        sh  = (ph >= 3) && (ph <= 2*n + 1) && (ph % 2 == 1);
        idx = (ev || sh) ? 6'((ph - 2) / 2) : 6'd0;
        return {ph == 1, ev && q, sh, (ph >= 1) && (ph <= 2*n + 1), ph == 2*n + 2, idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        ph5 = rst ? 0 : next_phase(ph5, 5, start, abort);
        ph2 = rst ? 0 : next_phase(ph2, 2, start2, abort2);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        rst = 1'b1; start = 1'b1; abort = 1'b0; q_lsb = 1'b1;
        start2 = 1'b1; abort2 = 1'b0; q2 = 1'b1;
        #2;
        for (int c = 0; c < 3; c++) begin
            obs = {load, acc_en, shift_en, busy, done, 3'b000, bit_idx};
            n_cmp++;
            if (obs !== 11'd0) begin
                n_bad++;
                $display("FAIL reset_n5 c=%0d got=%b want=%b", c, obs, 11'd0);
            end
            obs = {load2, acc_en2, shift_en2, busy2, done2, 4'b0000, bit_idx2};
            n_cmp++;
            if (obs !== 11'd0) begin
                n_bad++;
                $display("FAIL reset_n2 c=%0d got=%b want=%b", c, obs, 11'd0);
            end
            tick();
        end
        rst = 1'b0; start2 = 1'b0;
        #1;
        tick();
        start = 1'b0;
        #1;
        n_cmp++;
        if (load !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL first_edge_start got load=%b busy=%b want load=1 busy=1", load, busy);
        end
        for (int c = 0; c < 14; c++) begin
            q_lsb = 1'($urandom);
            #1;
            obs = {load, acc_en, shift_en, busy, done, 3'b000, bit_idx};
            n_cmp++;
            if (obs !== exp_out(ph5, 5, q_lsb)) begin
                n_bad++;
                $display("FAIL reset_drain c=%0d got=%b want=%b", c, obs, exp_out(ph5, 5, q_lsb));
            end
            tick();
        end
    endtask

    task automatic test_directed_mult(input logic [4:0] mult, input logic [13:0] want_acc);
        logic [10:0] obs;
        logic [13:0] acc_mask, done_mask;
        acc_mask = '0; done_mask = '0;
        for (int c = 0; c < 16; c++) begin
            start = (c == 0); abort = 1'b0;
            q_lsb = is_eval(ph5, 5) ? mult[(ph5 - 2) / 2] : 1'($urandom);
            #1;
            obs = {load, acc_en, shift_en, busy, done, 3'b000, bit_idx};
            if (c < 14) begin
                acc_mask[c]  = acc_en;
                done_mask[c] = done;
            end
            n_cmp++;
            if (obs !== exp_out(ph5, 5, q_lsb)) begin
                n_bad++;
                $display("FAIL mult_%b c=%0d got=%b want=%b", mult, c, obs, exp_out(ph5, 5, q_lsb));
            end
            tick();
        end
        n_cmp++;
        if (acc_mask !== want_acc) begin
            n_bad++;
            $display("FAIL mult_%b_acc_cycles got=%b want=%b", mult, acc_mask, want_acc);
        end
        n_cmp++;
        if (done_mask !== 14'(1 << 12)) begin
            n_bad++;
            $display("FAIL mult_%b_done_cycle got=%b want=%b", mult, done_mask, 14'(1 << 12));
        end
    endtask

    task automatic test_abort();
        logic [10:0] obs;
        logic [20:0] busy_mask, done_mask;
        busy_mask = '0; done_mask = '0;
        for (int c = 0; c < 21; c++) begin
            start = (c == 0); abort = (c == 7); q_lsb = 1'($urandom);
            #1;
            obs = {load, acc_en, shift_en, busy, done, 3'b000, bit_idx};
            busy_mask[c] = busy;
            done_mask[c] = done;
            n_cmp++;
            if (obs !== exp_out(ph5, 5, q_lsb)) begin
                n_bad++;
                $display("FAIL abort c=%0d got=%b want=%b", c, obs, exp_out(ph5, 5, q_lsb));
            end
            tick();
        end
        abort = 1'b0;
        n_cmp++;
        if (busy_mask !== 21'h0000FE) begin
            n_bad++;
            $display("FAIL abort_busy_cycles got=%h want=%h", busy_mask, 21'h0000FE);
        end
        n_cmp++;
        if (done_mask !== 21'd0) begin
            n_bad++;
            $display("FAIL abort_no_done got=%h want=0", done_mask);
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] obs;
        for (int c = 0; c < 5; c++) begin
            start = (c == 0); abort = 1'b0; q_lsb = 1'($urandom);
            #1;
            obs = {load, acc_en, shift_en, busy, done, 3'b000, bit_idx};
            n_cmp++;
            if (obs !== exp_out(ph5, 5, q_lsb)) begin
                n_bad++;
                $display("FAIL arst_pre c=%0d got=%b want=%b", c, obs, exp_out(ph5, 5, q_lsb));
            end
            tick();
        end
        start = 1'b0; q_lsb = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_busy_before got=%b want=1", busy);
        end
        rst = 1'b1;
        ph5 = 0; ph2 = 0;
        #1;
        obs = {load, acc_en, shift_en, busy, done, 3'b000, bit_idx};
        n_cmp++;
        if (obs !== 11'd0) begin
            n_bad++;
            $display("FAIL arst_immediate got=%b want=%b", obs, 11'd0);
        end
        #1;
        rst = 1'b0;
        tick();
        for (int c = 0; c < 16; c++) begin
            q_lsb = 1'($urandom);
            #1;
            obs = {load, acc_en, shift_en, busy, done, 3'b000, bit_idx};
            n_cmp++;
            if (obs !== exp_out(ph5, 5, q_lsb) || done !== 1'b0) begin
                n_bad++;
                $display("FAIL arst_idle c=%0d got=%b want=%b", c, obs, exp_out(ph5, 5, q_lsb));
            end
            tick();
        end
    endtask

    task automatic test_held_start();
        logic [10:0] obs;
        logic [26:0] load_mask, done_mask;
        load_mask = '0; done_mask = '0;
        for (int c = 0; c < 44; c++) begin
            start = (c < 30); abort = 1'b0; q_lsb = 1'($urandom);
            #1;
            obs = {load, acc_en, shift_en, busy, done, 3'b000, bit_idx};
            if (c < 27) begin
                load_mask[c] = load;
                done_mask[c] = done;
            end
            n_cmp++;
            if (obs !== exp_out(ph5, 5, q_lsb)) begin
                n_bad++;
                $display("FAIL held_start c=%0d got=%b want=%b", c, obs, exp_out(ph5, 5, q_lsb));
            end
            tick();
        end
        n_cmp++;
        if (load_mask !== 27'((1 << 1) | (1 << 14))) begin
            n_bad++;
            $display("FAIL held_load_cycles got=%b want=%b", load_mask, 27'((1 << 1) | (1 << 14)));
        end
        n_cmp++;
        if (done_mask !== 27'((1 << 12) | (1 << 25))) begin
            n_bad++;
            $display("FAIL held_done_cycles got=%b want=%b", done_mask, 27'((1 << 12) | (1 << 25)));
        end
    endtask

    task automatic test_n2();
        logic [10:0] obs;
        logic [7:0] acc_mask, done_mask;
        int exp_idx[6];
        exp_idx = '{0, 0, 0, 1, 1, 0};
        acc_mask = '0; done_mask = '0;
        for (int c = 0; c < 8; c++) begin
            start2 = (c == 0); abort2 = 1'b0; q2 = 1'b1;
            #1;
            obs = {load2, acc_en2, shift_en2, busy2, done2, 4'b0000, bit_idx2};
            acc_mask[c]  = acc_en2;
            done_mask[c] = done2;
            n_cmp++;
            if (obs !== exp_out(ph2, 2, q2)) begin
                n_bad++;
                $display("FAIL n2 c=%0d got=%b want=%b", c, obs, exp_out(ph2, 2, q2));
            end
            if (c >= 1 && c <= 6) begin
                n_cmp++;
                if (int'(bit_idx2) != exp_idx[c-1]) begin
                    n_bad++;
                    $display("FAIL n2_bit_idx c=%0d got=%0d want=%0d", c, bit_idx2, exp_idx[c-1]);
                end
            end
            tick();
        end
        n_cmp++;
        if (acc_mask !== 8'b0001_0100) begin
            n_bad++;
            $display("FAIL n2_acc_cycles got=%b want=%b", acc_mask, 8'b0001_0100);
        end
        n_cmp++;
        if (done_mask !== 8'b0100_0000) begin
            n_bad++;
            $display("FAIL n2_done_cycle got=%b want=%b", done_mask, 8'b0100_0000);
        end
    endtask

    task automatic test_random();
        logic [10:0] obs;
        for (int c = 0; c < 600; c++) begin
            start  = ($urandom_range(3) == 0);
            abort  = ($urandom_range(15) == 0);
            q_lsb  = 1'($urandom);
            start2 = ($urandom_range(2) == 0);
            abort2 = ($urandom_range(9) == 0);
            q2     = 1'($urandom);
            #1;
            obs = {load, acc_en, shift_en, busy, done, 3'b000, bit_idx};
            n_cmp++;
            if (obs !== exp_out(ph5, 5, q_lsb)) begin
                n_bad++;
                $display("FAIL random_n5 c=%0d got=%b want=%b", c, obs, exp_out(ph5, 5, q_lsb));
            end
            obs = {load2, acc_en2, shift_en2, busy2, done2, 4'b0000, bit_idx2};
            n_cmp++;
            if (obs !== exp_out(ph2, 2, q2)) begin
                n_bad++;
                $display("FAIL random_n2 c=%0d got=%b want=%b", c, obs, exp_out(ph2, 2, q2));
            end
            tick();
        end
        start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed_mult(5'b10110, 14'((1 << 4) | (1 << 6) | (1 << 10)));
        test_directed_mult(5'b00000, 14'd0);
        test_abort();
        test_async_reset();
        test_held_start();
        test_n2();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
